// File: rtl/fifo_pkg.sv
// Shared definitions for the team FIFO and its read-side drain controller:
// buffer occupancy encoding, FIFO geometry and a saturating counter helper.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 32;
    localparam int FIFO_DEPTH      = 8;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer: absorbs words returned by the FIFO and presents them
// on a valid/ready stream; the head word is held stable while stalled.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  m_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output occ_state_t            occ
);

    occ_state_t            occ_q, occ_d;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [DATA_WIDTH-1:0] mem_d [2];
    logic                  pop_s;
    logic                  wr_ok_s;

    assign m_valid = (occ_q != OCC_EMPTY);
    assign m_data  = mem_q[head_q];
    assign occ     = occ_q;

    // Next-state for occupancy, pointers and storage; a push into a full buffer is dropped.
    always_comb begin
        occ_d   = occ_q;
        head_d  = head_q;
        tail_d  = tail_q;
        mem_d   = mem_q;
        pop_s   = m_valid & m_ready;
        wr_ok_s = push & (occ_q != OCC_TWO);

        if (wr_ok_s) begin
            mem_d[tail_q] = push_data;
            tail_d        = ~tail_q;
        end else begin
            tail_d = tail_q;
        end

        if (pop_s) begin
            head_d = ~head_q;
        end else begin
            head_d = head_q;
        end

        case (occ_q)
            OCC_EMPTY: begin
                if (push) occ_d = OCC_ONE;
                else      occ_d = OCC_EMPTY;
            end
            OCC_ONE: begin
                if (push && !pop_s)      occ_d = OCC_TWO;
                else if (!push && pop_s) occ_d = OCC_EMPTY;
                else                     occ_d = OCC_ONE;
            end
            OCC_TWO: begin
                if (pop_s) occ_d = OCC_ONE;
                else       occ_d = OCC_TWO;
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    // Buffer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q    <= OCC_EMPTY;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            mem_q[0] <= {DATA_WIDTH{1'b0}};
            mem_q[1] <= {DATA_WIDTH{1'b0}};
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller for the 8-deep team FIFO: issues reads, tracks the
// one-cycle read latency and streams words out. Optional: FIFO_DRAIN_ERR_CNT_EN.
module fifo_drain_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic                  fifo_rd_ack,
    input  logic                  fifo_rd_err,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  busy,
    output logic [7:0]            err_count
);

    occ_state_t           occ_s;
    logic [1:0]           occ_bits_s;
    logic [2:0]           demand_s;
    logic                 pop_s;
    logic                 rd_en_s;
    logic                 inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0] word_count_q, word_count_d;

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_rd_ack),
        .push_data (fifo_dout),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .occ       (occ_s)
    );

    // Issue a read only when the buffer can take the word after this cycle's pop.
    // A read error needs no extra handling: inflight simply follows this cycle's issue.
    always_comb begin
        occ_bits_s   = occ_s;
        pop_s        = m_valid & m_ready;
        demand_s     = {1'b0, occ_bits_s} + {2'b00, inflight_q} - {2'b00, pop_s};
        rd_en_s      = !reset & enable & !fifo_empty & (demand_s < 3'd2);
        inflight_d   = rd_en_s;
        if (pop_s) begin
            word_count_d = word_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            word_count_d = word_count_q;
        end
    end

    // In-flight flag and delivered-word counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_q   <= 1'b0;
            word_count_q <= {CNT_WIDTH{1'b0}};
        end else begin
            inflight_q   <= inflight_d;
            word_count_q <= word_count_d;
        end
    end

    assign fifo_rd_en = rd_en_s;
    assign word_count = word_count_q;
    assign busy       = inflight_q | (occ_s != OCC_EMPTY);

`ifdef FIFO_DRAIN_ERR_CNT_EN
    logic [7:0] err_count_q, err_count_d;

    // Saturating read-error counter.
    always_comb begin
        if (fifo_rd_err) begin
            err_count_d = sat_inc8(err_count_q);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Error counter register, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_q <= 8'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    logic err_unused_s;
    assign err_unused_s = fifo_rd_err;
    assign err_count    = 8'd0;
`endif

endmodule
